// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the serial-adder request scheduler.
// Feature macro used by the controller: ADDER_TIMEOUT_EN.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      RESP
   } state_t;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_WIDTH   = 8;
   localparam int DEF_TIMEOUT = 32;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above the
// pointer wins, wrapping modulo N.
module rr_arbiter
   import serial_adder_pkg::*;
#(
   parameter int N  = DEF_NUM_REQ,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   always_comb begin
      int j;
      j       = 0;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = (int'(i_ptr) + k) % N;
         if (!o_any && i_req[IW'(j)]) begin
            o_any           = 1'b1;
            o_grant[IW'(j)] = 1'b1;
            o_idx           = IW'(j);
         end
      end
   end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Shares one serial adder among NUM_REQ requesters, round-robin.
// Define ADDER_TIMEOUT_EN to add a WAIT-state watchdog (rsp_err).
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int WIDTH          = DEF_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       rsp_valid,
   input  logic [NUM_REQ-1:0]       rsp_ready,
   output logic [WIDTH:0]           rsp_sum,
   output logic                     rsp_err,
   output logic                     add_start,
   output logic [WIDTH-1:0]         add_a,
   output logic [WIDTH-1:0]         add_b,
   input  logic [WIDTH:0]           add_sum,
   input  logic                     add_done
);

   localparam int IW = idx_w(NUM_REQ);

   state_t             r_state;
   state_t             w_next;
   logic [IW-1:0]      r_rr_ptr;
   logic [IW-1:0]      r_owner;
   logic [IW-1:0]      w_idx;
   logic [NUM_REQ-1:0] w_grant;
   logic               w_any;
   logic               w_idle;
   logic [WIDTH-1:0]   r_add_a;
   logic [WIDTH-1:0]   r_add_b;
   logic [WIDTH:0]     r_rsp_sum;
   logic               r_done_q;
   logic               w_done_ev;
   logic               w_tmo;
   logic               w_rsp_hs;

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_arb (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // Only a fresh rising edge of done counts; a stale high level is ignored.
   assign w_done_ev = add_done & ~r_done_q;
   assign w_idle    = (r_state == IDLE) & ~rst;
   assign w_rsp_hs  = (r_state == RESP) & rsp_ready[r_owner];

   assign req_ready = w_idle ? w_grant : '0;
   assign rsp_valid = (r_state == RESP) ? (NUM_REQ'(1) << r_owner) : '0;
   assign add_start = (r_state == START);
   assign add_a     = r_add_a;
   assign add_b     = r_add_b;
   assign rsp_sum   = r_rsp_sum;

`ifdef ADDER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] r_wcnt;
   logic          r_rsp_err;

   assign w_tmo   = (r_state == WAIT) & (r_wcnt == CW'(TIMEOUT_CYCLES - 1));
   assign rsp_err = r_rsp_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wcnt    <= '0;
         r_rsp_err <= 1'b0;
      end else begin
         if (r_state == START) r_wcnt <= '0;
         else if (r_state == WAIT) r_wcnt <= r_wcnt + 1'b1;
         if (r_state == WAIT) begin
            if (w_done_ev) r_rsp_err <= 1'b0;
            else if (w_tmo) r_rsp_err <= 1'b1;
         end
      end
   end
`else
   logic w_unused_to;

   assign w_unused_to = (TIMEOUT_CYCLES != 0);
   assign w_tmo       = 1'b0;
   assign rsp_err     = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_any) w_next = START;
         START:   w_next = WAIT;
         WAIT:    if (w_done_ev || w_tmo) w_next = RESP;
         RESP:    if (w_rsp_hs) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_rr_ptr  <= '0;
         r_owner   <= '0;
         r_add_a   <= '0;
         r_add_b   <= '0;
         r_rsp_sum <= '0;
         r_done_q  <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_done_q <= add_done;
         if (r_state == IDLE && w_any) begin
            r_add_a <= req_a[w_idx*WIDTH +: WIDTH];
            r_add_b <= req_b[w_idx*WIDTH +: WIDTH];
            r_owner <= w_idx;
         end
         if (r_state == WAIT && w_done_ev) r_rsp_sum <= add_sum;
         else if (w_tmo) r_rsp_sum <= '0;
         if (w_rsp_hs) begin
            r_rr_ptr <= (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl with a behavioural serial adder.
// Honours ADDER_TIMEOUT_EN to pick the expected watchdog behaviour.
module tb_serial_adder_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  req_ready;
   logic [3:0]  rsp_valid;
   logic [3:0]  rsp_ready;
   logic [8:0]  rsp_sum;
   logic        rsp_err;
   logic        add_start;
   logic [7:0]  add_a;
   logic [7:0]  add_b;
   logic [8:0]  add_sum;
   logic        add_done;

   int   total = 0;
   int   bad = 0;
   int   n_start = 0;
   int   m_cnt;
   logic [8:0] m_s;
   logic stuck = 1'b0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(
      .NUM_REQ        (4),
      .WIDTH          (8),
      .TIMEOUT_CYCLES (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_err   (rsp_err),
      .add_start (add_start),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_sum   (add_sum),
      .add_done  (add_done)
   );

   // Adder model: done from the last op stays high into the next WAIT.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         add_done <= 1'b0;
         add_sum  <= '0;
         m_cnt    <= 0;
         m_s      <= '0;
      end else if (add_start) begin
         m_s     <= {1'b0, add_a} + {1'b0, add_b};
         add_sum <= 9'h1AA;
         m_cnt   <= 4;
         n_start <= n_start + 1;
      end else if (stuck) begin
         add_done <= 1'b0;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 4) add_done <= 1'b0;
         if (m_cnt == 1) begin
            add_done <= 1'b1;
            add_sum  <= m_s;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_rdy(input int idx);
      int n;
      n = 0;
      #1;
      while (!req_ready[idx] && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("rdy_seen", 32'(req_ready[idx]), 1);
      chk("grant_1hot", 32'(req_ready), 32'(4'(1) << idx));
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (rsp_valid == 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic do_one(input int idx, input logic [7:0] a,
                         input logic [7:0] b, input logic [8:0] exp);
      int st;
      int n;
      st = n_start;
      req_a[idx*8 +: 8] = a;
      req_b[idx*8 +: 8] = b;
      req_valid[idx] = 1'b1;
      wait_rdy(idx);
      @(negedge clk);
      req_valid[idx] = 1'b0;
      wait_rsp(n);
      chk("rsp_valid", 32'(rsp_valid), 32'(4'(1) << idx));
      chk("rsp_sum", 32'(rsp_sum), 32'(exp));
      chk("rsp_err", 32'(rsp_err), 0);
      chk("add_a_hold", 32'(add_a), 32'(a));
      chk("start_pulses", n_start - st, 1);
      rsp_ready[idx] = 1'b1;
      @(negedge clk);
      rsp_ready[idx] = 1'b0;
      chk("rsp_drop", 32'(rsp_valid), 0);
   endtask

   initial begin
      int ord [5];
      logic [8:0] fs [4];
      int k;
      int r;
      int n;
      int st;
      logic ok;

      ord = '{0, 1, 2, 3, 0};
      fs  = '{9'h012, 9'h024, 9'h036, 9'h048};
      rst = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      req_a = '0;
      req_b = '0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_add_start", 32'(add_start), 0);
      chk("rst_add_a", 32'(add_a), 0);
      chk("rst_add_b", 32'(add_b), 0);
      chk("rst_rsp_sum", 32'(rsp_sum), 0);
      chk("rst_rsp_err", 32'(rsp_err), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      do_one(0, 8'h2A, 8'h55, 9'h07F);
      do_one(2, 8'hFF, 8'h01, 9'h100);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      req_a = 32'h4433_2211;
      req_b = 32'h0403_0201;
      req_valid = 4'hF;
      rsp_ready = 4'hF;
      k = 0;
      r = 0;
      for (int c = 0; c < 200 && r < 5; c++) begin
         #1;
         if (req_ready != 0 && k < 5) begin
            chk("fair_cnt1", $countones(req_ready), 1);
            chk("fair_grant", 32'(req_ready), 32'(4'(1) << ord[k]));
            k++;
         end
         if (rsp_valid != 0) begin
            chk("fair_rsp", 32'(rsp_valid), 32'(4'(1) << ord[r]));
            chk("fair_sum", 32'(rsp_sum), 32'(fs[ord[r]]));
            r++;
         end
         @(negedge clk);
         if (k == 5) req_valid = '0;
      end
      chk("fair_done", r, 5);
      rsp_ready = '0;
      req_valid = '0;

      req_a[15:0] = 16'h3C01;
      req_b[15:0] = 16'h0F01;
      req_valid = 4'b0011;
      wait_rdy(1);
      @(negedge clk);
      req_valid = 4'b0001;
      rsp_ready = 4'b0001;
      wait_rsp(n);
      chk("bp_rsp", 32'(rsp_valid), 32'h2);
      chk("bp_sum", 32'(rsp_sum), 32'h04B);
      st = n_start;
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         #1;
         if (rsp_valid != 4'b0010 || rsp_sum != 9'h04B ||
             req_ready != 0 || add_start) ok = 1'b0;
      end
      chk("bp_stable", 32'(ok), 1);
      chk("bp_nostart", n_start - st, 0);
      req_valid = '0;
      rsp_ready = 4'b0010;
      @(negedge clk);
      rsp_ready = '0;
      chk("bp_release", 32'(rsp_valid), 0);

      req_a = 32'h0110_007F;
      req_b = 32'h0220_0080;
      req_valid = 4'b1000;
      wait_rdy(3);
      @(negedge clk);
      req_valid = 4'b0101;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst_req_ready", 32'(req_ready), 0);
      chk("mrst_rsp_valid", 32'(rsp_valid), 0);
      chk("mrst_add_start", 32'(add_start), 0);
      chk("mrst_add_a", 32'(add_a), 0);
      chk("mrst_add_b", 32'(add_b), 0);
      chk("mrst_rsp_sum", 32'(rsp_sum), 0);
      chk("mrst_rsp_err", 32'(rsp_err), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_grant0", 32'(req_ready), 32'h1);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(n);
      chk("mrst_rsp", 32'(rsp_valid), 32'h1);
      chk("mrst_sum", 32'(rsp_sum), 32'h0FF);
      rsp_ready = 4'b0001;
      @(negedge clk);
      rsp_ready = '0;

      stuck = 1'b1;
      req_a[15:8] = 8'h05;
      req_b[15:8] = 8'h06;
      req_valid = 4'b0010;
      wait_rdy(1);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(n);
`ifdef ADDER_TIMEOUT_EN
      chk("to_latency", n, 33);
      chk("to_rsp", 32'(rsp_valid), 32'h2);
      chk("to_err", 32'(rsp_err), 1);
      chk("to_sum", 32'(rsp_sum), 0);
      rsp_ready = 4'b0010;
      @(negedge clk);
      rsp_ready = '0;
`else
      chk("no_to_rsp", 32'(rsp_valid), 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
`endif
      stuck = 1'b0;
      @(negedge clk);
      do_one(2, 8'h80, 8'h80, 9'h100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
